uart_message_streamer: RTL and testbench

//  Streams a runtime-loadable message (up to MSG_DEPTH bytes) into the uart transmit interface,
//  one byte per uart frame, with single-shot or repeating mode and a programmable inter-pass gap.

---
 rtl/uart_message_streamer.sv | 153 +++++++++++++++
 tb/tb_uart_message_streamer.sv | 480 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_message_streamer.sv
// Streams a runtime-loaded byte buffer into a UART transmitter, one byte per frame,
// with single-shot or repeating passes, a fixed inter-pass gap, and immediate abort.
module uart_message_streamer #(
    parameter int MSG_DEPTH  = 16,
    parameter int GAP_CYCLES = 0,
    localparam int AW        = $clog2(MSG_DEPTH)
) (
    input  logic          clk_i,
    input  logic          rst_i,
    input  logic          wr_en_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic [7:0]    wr_data_i,
    input  logic [AW:0]   msg_len_i,
    input  logic          start_i,
    input  logic          repeat_en_i,
    input  logic          abort_i,
    input  logic          tx_busy_i,
    output logic          tx_transmit_o,
    output logic [7:0]    tx_byte_o,
    output logic          busy_o,
    output logic          done_o,
    output logic [AW-1:0] byte_idx_o,
    output logic [2:0]    dbg_state_o
);

    localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
    localparam logic [GW-1:0] GAP_LAST  = GW'((GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0);
    localparam logic [AW:0]   DEPTH_LEN = (AW + 1)'(MSG_DEPTH);
    localparam logic [AW:0]   LEN_ONE   = (AW + 1)'(1);

    // Handshake: the UART accepts a byte when tx_transmit is high for one cycle
    // while tx_busy is low; tx_busy then rises and stays high until the frame ends.
    typedef enum logic [2:0] {
        IDLE       = 3'd0,
        SEND       = 3'd1,
        WAIT_START = 3'd2,
        WAIT_DONE  = 3'd3,
        GAP        = 3'd4
    } state_t;

    state_t         state_q;
    logic           tx_transmit_q;
    logic [7:0]     tx_byte_q;
    logic           done_q;
    logic [AW-1:0]  byte_idx_q;
    logic [AW:0]    len_q;
    logic [GW-1:0]  gap_cnt_q;

    logic [7:0]     mem_q [MSG_DEPTH];

    logic [7:0]     tx_byte_d;
    logic           last_byte_d;
    logic [AW:0]    len_d;

    // Buffer contents survive reset; a same-edge write leaves the read with the old byte.
    always_ff @(posedge clk_i) begin
        if (wr_en_i) begin
            mem_q[wr_addr_i] <= wr_data_i;
        end
    end

    always_comb begin
        tx_byte_d   = mem_q[byte_idx_q];
        last_byte_d = ({1'b0, byte_idx_q} == (len_q - LEN_ONE));
        len_d       = (msg_len_i > DEPTH_LEN) ? DEPTH_LEN : msg_len_i;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q       <= IDLE;
            tx_transmit_q <= 1'b0;
            tx_byte_q     <= 8'h00;
            done_q        <= 1'b0;
            byte_idx_q    <= '0;
            len_q         <= '0;
            gap_cnt_q     <= '0;
        end else begin
            done_q <= 1'b0;
            if (abort_i) begin
                // A byte already taken by the UART finishes on the line on its own.
                state_q       <= IDLE;
                tx_transmit_q <= 1'b0;
            end else begin
                case (state_q)
                    IDLE: begin
                        if (start_i) begin
                            if (msg_len_i != '0) begin
                                len_q      <= len_d;
                                byte_idx_q <= '0;
                                state_q    <= SEND;
                            end else begin
                                done_q <= 1'b1;
                            end
                        end
                    end
                    SEND: begin
                        if (!tx_busy_i) begin
                            tx_transmit_q <= 1'b1;
                            tx_byte_q     <= tx_byte_d;
                            state_q       <= WAIT_START;
                        end
                    end
                    WAIT_START: begin
                        tx_transmit_q <= 1'b0;
                        if (tx_busy_i) begin
                            state_q <= WAIT_DONE;
                        end
                    end
                    WAIT_DONE: begin
                        if (!tx_busy_i) begin
                            if (!last_byte_d) begin
                                byte_idx_q <= byte_idx_q + AW'(1);
                                state_q    <= SEND;
                            end else begin
                                done_q <= 1'b1;
                                if (repeat_en_i) begin
                                    if (GAP_CYCLES == 0) begin
                                        byte_idx_q <= '0;
                                        state_q    <= SEND;
                                    end else begin
                                        gap_cnt_q <= GAP_LAST;
                                        state_q   <= GAP;
                                    end
                                end else begin
                                    state_q <= IDLE;
                                end
                            end
                        end
                    end
                    GAP: begin
                        if (gap_cnt_q == '0) begin
                            byte_idx_q <= '0;
                            state_q    <= SEND;
                        end else begin
                            gap_cnt_q <= gap_cnt_q - GW'(1);
                        end
                    end
                    default: begin
                        state_q <= IDLE;
                    end
                endcase
            end
        end
    end

    assign tx_transmit_o = tx_transmit_q;
    assign tx_byte_o     = tx_byte_q;
    assign busy_o        = (state_q != IDLE);
    assign done_o        = done_q;
    assign byte_idx_o    = byte_idx_q;
    assign dbg_state_o   = state_q;

endmodule

// File: tb/tb_uart_message_streamer.sv
// Bench for uart_message_streamer: a UART busy model, a byte scoreboard fed at stimulus
// time and drained on each strobe, and one task per scenario.
module tb_uart_message_streamer;

    localparam int MSG_DEPTH  = 16;
    localparam int GAP_CYCLES = 5;
    localparam int AW         = 4;
    localparam int UART_CYC   = 10;

    localparam logic [2:0] ST_IDLE      = 3'd0;
    localparam logic [2:0] ST_SEND      = 3'd1;
    localparam logic [2:0] ST_WAIT_DONE = 3'd3;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          wr_en = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [7:0]    wr_data = 8'h00;
    logic [AW:0]   msg_len = '0;
    logic          start = 1'b0;
    logic          repeat_en = 1'b0;
    logic          abort = 1'b0;
    logic          model_busy = 1'b0;
    logic          hold_busy = 1'b0;
    logic          tx_busy;
    logic          tx_transmit;
    logic [7:0]    tx_byte;
    logic          busy;
    logic          done;
    logic [AW-1:0] byte_idx;
    logic [2:0]    dbg_state;

    assign tx_busy = model_busy | hold_busy;

    uart_message_streamer #(.MSG_DEPTH(MSG_DEPTH), .GAP_CYCLES(GAP_CYCLES)) dut (
        .clk_i(clk), .rst_i(rst), .wr_en_i(wr_en), .wr_addr_i(wr_addr), .wr_data_i(wr_data),
        .msg_len_i(msg_len), .start_i(start), .repeat_en_i(repeat_en), .abort_i(abort),
        .tx_busy_i(tx_busy), .tx_transmit_o(tx_transmit), .tx_byte_o(tx_byte), .busy_o(busy),
        .done_o(done), .byte_idx_o(byte_idx), .dbg_state_o(dbg_state)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    int strobe_cnt = 0;
    int done_cnt = 0;
    int first_strobe_cyc = 0;
    int start_cyc = 0;
    int done_cyc = 0;
    int fall_cyc = 0;
    int last_gap = 0;
    int uart_cnt = 0;
    logic busy_at_edge = 1'b0;
    logic prev_strobe = 1'b0;
    logic [11:0] exp_q[$];
    logic [7:0]  mem_model [MSG_DEPTH];
    logic [7:0]  hello [12] = '{8'h48, 8'h65, 8'h6C, 8'h6C, 8'h6F, 8'h20,
                                8'h57, 8'h6F, 8'h72, 8'h6C, 8'h64, 8'h21};

    always @(posedge clk) begin
        cyc <= cyc + 1;
        busy_at_edge <= tx_busy;
    end

    // UART model: busy for UART_CYC cycles after each accepted strobe.
    always @(negedge clk) begin
        if (uart_cnt != 0) begin
            uart_cnt = uart_cnt - 1;
            if (uart_cnt == 0) fall_cyc = cyc;
        end
        if (tx_transmit) uart_cnt = UART_CYC;
        model_busy = (uart_cnt != 0);
    end

    // ---------------- scoreboard ----------------
    always @(negedge clk) begin
        logic [11:0] got;
        logic [11:0] exp;
        if (tx_transmit) begin
            if (strobe_cnt == 0) first_strobe_cyc = cyc;
            strobe_cnt = strobe_cnt + 1;
            if (byte_idx == '0) last_gap = cyc - fall_cyc;
            total = total + 1;
            if (busy_at_edge !== 1'b0) begin
                bad = bad + 1;
                $display("FAIL strobe_while_busy: got tx_busy=%b at strobe edge, need 0", busy_at_edge);
            end
            total = total + 1;
            got = {byte_idx, tx_byte};
            if (exp_q.size() == 0) begin
                bad = bad + 1;
                $display("FAIL unexpected_strobe: got idx=%0d byte=%02h, need no strobe", byte_idx, tx_byte);
            end else begin
                exp = exp_q.pop_front();
                if (got !== exp) begin
                    bad = bad + 1;
                    $display("FAIL byte_data: got idx=%0d byte=%02h, need idx=%0d byte=%02h",
                             got[11:8], got[7:0], exp[11:8], exp[7:0]);
                end
            end
            if (prev_strobe) begin
                total = total + 1;
                bad = bad + 1;
                $display("FAIL strobe_width: got strobe high 2 cycles, need 1");
            end
        end
        prev_strobe = tx_transmit;
        if (done) begin
            done_cnt = done_cnt + 1;
            done_cyc = cyc;
        end
    end

    // ---------------- driver tasks ----------------
    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic write_byte(input int a, input logic [7:0] d);
        wr_en = 1'b1;
        wr_addr = AW'(a);
        wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
        mem_model[a] = d;
    endtask

    task automatic push_pass(input int len);
        logic [AW-1:0] ix;
        for (int i = 0; i < len; i++) begin
            ix = AW'(i);
            exp_q.push_back({ix, mem_model[i]});
        end
    endtask

    task automatic pulse_start(input int len);
        msg_len = (AW + 1)'(len);
        start = 1'b1;
        start_cyc = cyc;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_done(input int target, input int budget);
        for (int i = 0; i < budget && done_cnt < target; i++) @(negedge clk);
    endtask

    task automatic wait_strobes(input int target, input int budget);
        for (int i = 0; i < budget && strobe_cnt < target; i++) @(negedge clk);
    endtask

    task automatic wait_idle();
        for (int i = 0; i < 200 && (busy || uart_cnt != 0); i++) @(negedge clk);
    endtask

    task automatic clear_counts();
        strobe_cnt = 0;
        done_cnt = 0;
    endtask

    // ---------------- scenarios ----------------
    task automatic test_reset();
        rst = 1'b1;
        tick(3);
        total = total + 1;
        if ({tx_transmit, tx_byte, busy, done, byte_idx, dbg_state} !== '0) begin
            bad = bad + 1;
            $display("FAIL reset_outputs: got strobe=%b byte=%02h busy=%b done=%b idx=%0d st=%0d, need all 0",
                     tx_transmit, tx_byte, busy, done, byte_idx, dbg_state);
        end
        rst = 1'b0;
        tick(1);
        total = total + 1;
        if (busy !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL reset_release_busy: got %b need 0", busy);
        end
    endtask

    task automatic test_hello();
        for (int i = 0; i < 12; i++) write_byte(i, hello[i]);
        clear_counts();
        repeat_en = 1'b0;
        push_pass(12);
        pulse_start(12);
        wait_done(1, 400);
        tick(2);
        total = total + 5;
        if (first_strobe_cyc - start_cyc !== 2) begin
            bad = bad + 1;
            $display("FAIL hello_latency: got %0d need 2", first_strobe_cyc - start_cyc);
        end
        if (strobe_cnt !== 12) begin
            bad = bad + 1;
            $display("FAIL hello_strobes: got %0d need 12", strobe_cnt);
        end
        if (done_cnt !== 1) begin
            bad = bad + 1;
            $display("FAIL hello_done: got %0d need 1", done_cnt);
        end
        if (busy !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL hello_busy_after: got %b need 0", busy);
        end
        if (exp_q.size() !== 0) begin
            bad = bad + 1;
            $display("FAIL hello_leftover: got %0d need 0", exp_q.size());
        end
        wait_idle();
    endtask

    task automatic test_repeat_gap();
        write_byte(0, 8'h41);
        write_byte(1, 8'h42);
        write_byte(2, 8'h43);
        clear_counts();
        repeat_en = 1'b1;
        push_pass(3);
        push_pass(3);
        push_pass(3);
        pulse_start(3);
        msg_len = 5'd9;
        wait_done(2, 400);
        total = total + 1;
        if (last_gap !== GAP_CYCLES + 2) begin
            bad = bad + 1;
            $display("FAIL repeat_gap: got %0d need %0d", last_gap, GAP_CYCLES + 2);
        end
        wait_strobes(7, 200);
        repeat_en = 1'b0;
        wait_done(3, 400);
        tick(3);
        total = total + 4;
        if (done_cnt !== 3) begin
            bad = bad + 1;
            $display("FAIL repeat_done: got %0d need 3", done_cnt);
        end
        if (strobe_cnt !== 9) begin
            bad = bad + 1;
            $display("FAIL repeat_strobes: got %0d need 9", strobe_cnt);
        end
        if (busy !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL repeat_stop_busy: got %b need 0", busy);
        end
        if (last_gap !== GAP_CYCLES + 2) begin
            bad = bad + 1;
            $display("FAIL repeat_gap3: got %0d need %0d", last_gap, GAP_CYCLES + 2);
        end
        wait_idle();
    endtask

    task automatic test_zero_len();
        clear_counts();
        pulse_start(0);
        tick(3);
        total = total + 4;
        if (done_cnt !== 1) begin
            bad = bad + 1;
            $display("FAIL zero_done: got %0d need 1", done_cnt);
        end
        if (done_cyc !== start_cyc + 1) begin
            bad = bad + 1;
            $display("FAIL zero_done_time: got %0d need %0d", done_cyc, start_cyc + 1);
        end
        if (strobe_cnt !== 0) begin
            bad = bad + 1;
            $display("FAIL zero_strobes: got %0d need 0", strobe_cnt);
        end
        if (busy !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL zero_busy: got %b need 0", busy);
        end
    endtask

    task automatic test_full_len();
        for (int i = 0; i < MSG_DEPTH; i++) write_byte(i, 8'($urandom_range(0, 255)));
        clear_counts();
        push_pass(MSG_DEPTH);
        pulse_start(MSG_DEPTH);
        wait_done(1, 500);
        tick(2);
        total = total + 3;
        if (strobe_cnt !== MSG_DEPTH) begin
            bad = bad + 1;
            $display("FAIL full_strobes: got %0d need %0d", strobe_cnt, MSG_DEPTH);
        end
        if (done_cnt !== 1) begin
            bad = bad + 1;
            $display("FAIL full_done: got %0d need 1", done_cnt);
        end
        if (exp_q.size() !== 0) begin
            bad = bad + 1;
            $display("FAIL full_leftover: got %0d need 0", exp_q.size());
        end
        wait_idle();
    endtask

    task automatic test_abort();
        for (int i = 0; i < 12; i++) write_byte(i, hello[i]);
        clear_counts();
        push_pass(5);
        pulse_start(12);
        wait_strobes(5, 200);
        tick(3);
        total = total + 1;
        if (dbg_state !== ST_WAIT_DONE || byte_idx !== 4'd4) begin
            bad = bad + 1;
            $display("FAIL abort_setup: got st=%0d idx=%0d need st=%0d idx=4", dbg_state, byte_idx, ST_WAIT_DONE);
        end
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        total = total + 1;
        if (busy !== 1'b0 || dbg_state !== ST_IDLE || tx_transmit !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL abort_idle: got busy=%b st=%0d strobe=%b need 0 0 0", busy, dbg_state, tx_transmit);
        end
        tick(30);
        total = total + 2;
        if (strobe_cnt !== 5) begin
            bad = bad + 1;
            $display("FAIL abort_strobes: got %0d need 5", strobe_cnt);
        end
        if (done_cnt !== 0) begin
            bad = bad + 1;
            $display("FAIL abort_done: got %0d need 0", done_cnt);
        end
        clear_counts();
        push_pass(3);
        pulse_start(3);
        wait_done(1, 200);
        tick(2);
        total = total + 1;
        if (strobe_cnt !== 3 || done_cnt !== 1) begin
            bad = bad + 1;
            $display("FAIL abort_restart: got strobes=%0d done=%0d need 3 1", strobe_cnt, done_cnt);
        end
        wait_idle();
    endtask

    task automatic test_reset_mid();
        clear_counts();
        push_pass(12);
        pulse_start(12);
        wait_strobes(3, 200);
        tick(2);
        rst = 1'b1;
        @(negedge clk);
        total = total + 1;
        if ({tx_transmit, tx_byte, busy, done, byte_idx} !== '0) begin
            bad = bad + 1;
            $display("FAIL midrst_outputs: got strobe=%b byte=%02h busy=%b done=%b idx=%0d need all 0",
                     tx_transmit, tx_byte, busy, done, byte_idx);
        end
        rst = 1'b0;
        exp_q.delete();
        tick(30);
        total = total + 1;
        if (strobe_cnt !== 3 || done_cnt !== 0) begin
            bad = bad + 1;
            $display("FAIL midrst_quiet: got strobes=%0d done=%0d need 3 0", strobe_cnt, done_cnt);
        end
        wait_idle();
    endtask

    task automatic test_start_ignored();
        clear_counts();
        push_pass(3);
        pulse_start(3);
        for (int k = 0; k < 3; k++) begin
            tick(5);
            msg_len = 5'd8;
            start = 1'b1;
            tick(1);
            start = 1'b0;
        end
        wait_done(1, 300);
        tick(3);
        total = total + 1;
        if (strobe_cnt !== 3 || done_cnt !== 1) begin
            bad = bad + 1;
            $display("FAIL start_busy_ignored: got strobes=%0d done=%0d need 3 1", strobe_cnt, done_cnt);
        end
        wait_idle();
        clear_counts();
        msg_len = 5'd3;
        start = 1'b1;
        abort = 1'b1;
        @(negedge clk);
        start = 1'b0;
        abort = 1'b0;
        total = total + 1;
        if (busy !== 1'b0) begin
            bad = bad + 1;
            $display("FAIL start_abort_busy: got %b need 0", busy);
        end
        tick(10);
        total = total + 1;
        if (strobe_cnt !== 0 || done_cnt !== 0) begin
            bad = bad + 1;
            $display("FAIL start_abort_quiet: got strobes=%0d done=%0d need 0 0", strobe_cnt, done_cnt);
        end
    endtask

    task automatic test_write_during();
        logic [AW-1:0] ix;
        for (int i = 0; i < 4; i++) write_byte(i, 8'h10 + 8'(i));
        clear_counts();
        for (int i = 0; i < 4; i++) begin
            ix = AW'(i);
            exp_q.push_back({ix, (i == 2) ? 8'hA5 : mem_model[i]});
        end
        pulse_start(4);
        wait_strobes(2, 200);
        write_byte(2, 8'hA5);
        wait_done(1, 300);
        tick(2);
        total = total + 1;
        if (strobe_cnt !== 4 || exp_q.size() !== 0) begin
            bad = bad + 1;
            $display("FAIL write_during: got strobes=%0d left=%0d need 4 0", strobe_cnt, exp_q.size());
        end
        wait_idle();
    endtask

    task automatic test_busy_hold();
        hold_busy = 1'b1;
        clear_counts();
        push_pass(2);
        pulse_start(2);
        tick(20);
        total = total + 1;
        if (strobe_cnt !== 0 || busy !== 1'b1 || dbg_state !== ST_SEND) begin
            bad = bad + 1;
            $display("FAIL hold_no_strobe: got strobes=%0d busy=%b st=%0d need 0 1 %0d",
                     strobe_cnt, busy, dbg_state, ST_SEND);
        end
        hold_busy = 1'b0;
        wait_done(1, 200);
        tick(2);
        total = total + 1;
        if (strobe_cnt !== 2 || done_cnt !== 1) begin
            bad = bad + 1;
            $display("FAIL hold_release: got strobes=%0d done=%0d need 2 1", strobe_cnt, done_cnt);
        end
        wait_idle();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout need completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        @(negedge clk);
        test_reset();
        test_hello();
        test_repeat_gap();
        test_zero_len();
        test_full_len();
        test_abort();
        test_reset_mid();
        test_start_ignored();
        test_write_during();
        test_busy_hold();
        total = total + 1;
        if (exp_q.size() !== 0) begin
            bad = bad + 1;
            $display("FAIL final_queue: got %0d need 0", exp_q.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
